// File: rtl/rhs_spi_master.sv
// ---------------------------------------------------------------------------
// rhs_spi_master
//
// SPI master sequencer for the RHS front end. Each accepted start sweeps
// NUM_CHANNELS+2 frames of 32-bit CONVERT commands (SPI mode 0, MSB first).
// The slave answers two frames late, so the MISO word of frame k belongs to
// channel k-2. The first two responses of a sweep are dropped.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   start          sweep request, sampled only in IDLE
//   busy           high while a sweep is in progress
//   CS             active-low chip select
//   SCLK           SPI clock, idles low
//   MOSI           command bit stream
//   MISO           response bit stream from the slave
//   sample_data    MISO[31:16] of the frame that carries the sample
//   sample_channel channel the sample belongs to
//   sample_valid   one-cycle strobe qualifying sample_data/sample_channel
//   frame_done     one-cycle strobe at the end of a sweep
//
// Build option
//   RHS_SPI_MASTER_CONTINUOUS_EN : when defined, start held high at the end
//   of the last frame chains straight into a new sweep without visiting IDLE.
// ---------------------------------------------------------------------------
module rhs_spi_master #(
    parameter int CLK_DIV        = 2,
    parameter int NUM_CHANNELS   = 16,
    parameter int CS_HIGH_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        CS,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic [15:0] sample_data,
    output logic [5:0]  sample_channel,
    output logic        sample_valid,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SCLK_HI,
        SCLK_LO,
        CS_HOLD,
        CS_GAP
    } state_t;

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_RELOAD = 8'(CS_HIGH_CYCLES - 1);
    localparam logic [6:0] LAST_FRAME = 7'(NUM_CHANNELS + 1);
    localparam logic [6:0] NUM_CH_W   = 7'(NUM_CHANNELS);
    localparam logic [5:0] LAST_CH    = 6'(NUM_CHANNELS - 1);

    state_t      state_reg;
    logic [7:0]  div_cnt_reg;
    logic [4:0]  bit_cnt_reg;     // index of the bit currently on the wire
    logic [6:0]  frame_cnt_reg;   // k = 0 .. NUM_CHANNELS+1
    logic [15:0] rx_reg;          // upper half of the MISO word

    logic [5:0]  cmd_ch;
    logic [31:0] cmd_word;
    logic [4:0]  bit_dec;

    // The two flush frames repeat the last channel so the slave stays in range.
    assign cmd_ch   = (frame_cnt_reg < NUM_CH_W) ? frame_cnt_reg[5:0] : LAST_CH;
    assign cmd_word = {2'b00, 8'h00, cmd_ch, 16'h0000};
    assign bit_dec  = bit_cnt_reg - 5'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            div_cnt_reg    <= '0;
            bit_cnt_reg    <= '0;
            frame_cnt_reg  <= '0;
            rx_reg         <= '0;
            busy           <= 1'b0;
            CS             <= 1'b1;
            SCLK           <= 1'b0;
            MOSI           <= 1'b0;
            sample_data    <= '0;
            sample_channel <= '0;
            sample_valid   <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg     <= CS_SETUP;
                        busy          <= 1'b1;
                        CS            <= 1'b0;
                        MOSI          <= 1'b0;   // command MSB is always 0
                        frame_cnt_reg <= '0;
                        bit_cnt_reg   <= 5'd31;
                        div_cnt_reg   <= DIV_RELOAD;
                    end
                end

                CS_SETUP: begin
                    if (div_cnt_reg == 8'd0) begin
                        state_reg   <= SCLK_HI;
                        SCLK        <= 1'b1;
                        rx_reg      <= {rx_reg[14:0], MISO};
                        div_cnt_reg <= DIV_RELOAD;
                    end else begin
                        div_cnt_reg <= div_cnt_reg - 8'd1;
                    end
                end

                SCLK_HI: begin
                    if (div_cnt_reg == 8'd0) begin
                        state_reg   <= SCLK_LO;
                        SCLK        <= 1'b0;
                        MOSI        <= (bit_cnt_reg != 5'd0) ? cmd_word[bit_dec] : 1'b0;
                        div_cnt_reg <= DIV_RELOAD;
                    end else begin
                        div_cnt_reg <= div_cnt_reg - 8'd1;
                    end
                end

                SCLK_LO: begin
                    if (div_cnt_reg == 8'd0) begin
                        div_cnt_reg <= DIV_RELOAD;
                        if (bit_cnt_reg == 5'd0) begin
                            state_reg <= CS_HOLD;
                            // Responses of the first two frames are pipeline fill.
                            if (frame_cnt_reg >= 7'd2) begin
                                sample_valid   <= 1'b1;
                                sample_data    <= rx_reg;
                                sample_channel <= 6'(frame_cnt_reg - 7'd2);
                            end
                        end else begin
                            state_reg   <= SCLK_HI;
                            SCLK        <= 1'b1;
                            bit_cnt_reg <= bit_dec;
                            // Only bits 31..16 are kept; once bit 16 is in,
                            // the register holds the sample word.
                            if (bit_dec[4]) begin
                                rx_reg <= {rx_reg[14:0], MISO};
                            end
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg - 8'd1;
                    end
                end

                CS_HOLD: begin
                    if (div_cnt_reg == 8'd0) begin
                        state_reg   <= CS_GAP;
                        CS          <= 1'b1;
                        div_cnt_reg <= GAP_RELOAD;
                    end else begin
                        div_cnt_reg <= div_cnt_reg - 8'd1;
                    end
                end

                CS_GAP: begin
                    if (div_cnt_reg == 8'd0) begin
                        if (frame_cnt_reg == LAST_FRAME) begin
                            frame_done <= 1'b1;
`ifdef RHS_SPI_MASTER_CONTINUOUS_EN
                            if (start) begin
                                state_reg     <= CS_SETUP;
                                CS            <= 1'b0;
                                MOSI          <= 1'b0;
                                frame_cnt_reg <= '0;
                                bit_cnt_reg   <= 5'd31;
                                div_cnt_reg   <= DIV_RELOAD;
                            end else begin
                                state_reg <= IDLE;
                                busy      <= 1'b0;
                            end
`else
                            state_reg <= IDLE;
                            busy      <= 1'b0;
`endif
                        end else begin
                            state_reg     <= CS_SETUP;
                            CS            <= 1'b0;
                            MOSI          <= 1'b0;
                            frame_cnt_reg <= frame_cnt_reg + 7'd1;
                            bit_cnt_reg   <= 5'd31;
                            div_cnt_reg   <= DIV_RELOAD;
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg - 8'd1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    CS        <= 1'b1;
                    SCLK      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rhs_spi_master.sv
// ---------------------------------------------------------------------------
// tb_rhs_spi_master
//
// Scoreboard bench for rhs_spi_master with default parameters. Stimulus
// pushes the expected {channel, data} of every sample into a queue; a
// negedge monitor pops and compares on each sample_valid, decodes MOSI per
// frame and checks SCLK/CS shape. The MISO model either returns
// {16'hA000+k, 16'h0} in frame k, or behaves like a slave whose channel k
// reads k+2 and answers two frames after the command.
// ---------------------------------------------------------------------------
module tb_rhs_spi_master;

    localparam int CLK_DIV   = 2;
    localparam int NCH       = 16;
    localparam int CSH       = 4;
    localparam int FRAME_LEN = CLK_DIV * 66 + CSH;
    localparam int SWEEP_LEN = (NCH + 2) * FRAME_LEN;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        cs;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic [15:0] sample_data;
    logic [5:0]  sample_channel;
    logic        sample_valid;
    logic        frame_done;

    always #5 clk = ~clk;

    rhs_spi_master #(
        .CLK_DIV        (CLK_DIV),
        .NUM_CHANNELS   (NCH),
        .CS_HIGH_CYCLES (CSH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .CS             (cs),
        .SCLK           (sclk),
        .MOSI           (mosi),
        .MISO           (miso),
        .sample_data    (sample_data),
        .sample_channel (sample_channel),
        .sample_valid   (sample_valid),
        .frame_done     (frame_done)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [5:0]  ch;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [5:0]  cmd_hist[$];
    int          slave_mode = 0;
    int          cs_falls = 0;
    int          nfall = 32;
    int          nrise = 0;
    int          hi_run = 0;
    int          gap_run = 0;
    int          busy_cycles = 0;
    int          done_count = 0;
    bit          sclk_bad = 1'b0;
    bit          idle_bad = 1'b0;
    logic        cs_prev = 1'b1;
    logic        sclk_prev = 1'b0;
    logic [31:0] mosi_word = '0;
    logic [31:0] miso_word = '0;

    assign miso = (nfall < 32) ? miso_word[5'(31 - nfall)] : 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: scoreboard pop plus SPI framing/command decode.
    always @(negedge clk) begin
        exp_t        e;
        int          k;
        int          chx;
        logic [31:0] exp_cmd;
        if (rst) begin
            cs_prev   = 1'b1;
            sclk_prev = 1'b0;
            nfall     = 32;
            nrise     = 0;
            hi_run    = 0;
            gap_run   = 0;
            sclk_bad  = 1'b0;
        end else begin
            if (busy)       busy_cycles++;
            if (frame_done) done_count++;
            if (cs && sclk) idle_bad = 1'b1;

            if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe actual=ch%0d/0x%0h required=no strobe at %0t",
                             sample_channel, sample_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sample_channel", 32'(sample_channel), 32'(e.ch));
                    check("sample_data", 32'(sample_data), 32'(e.data));
                end
            end

            if (cs_prev && !cs) begin
                if (cs_falls > 0) check("cs_gap", gap_run, CSH);
                k = cs_falls;
                cs_falls++;
                nfall     = 0;
                nrise     = 0;
                hi_run    = 0;
                sclk_bad  = 1'b0;
                mosi_word = '0;
                if (slave_mode == 0)
                    miso_word = {16'hA000 + 16'(k), 16'h0000};
                else if (k >= 2 && cmd_hist.size() >= k - 1)
                    miso_word = {16'(cmd_hist[k-2]) + 16'd2, 16'h0000};
                else
                    miso_word = '0;
            end

            if (!cs) begin
                if (!sclk_prev && sclk) begin
                    nrise++;
                    mosi_word = {mosi_word[30:0], mosi};
                    hi_run = 0;
                end
                if (sclk) hi_run++;
                if (sclk_prev && !sclk) begin
                    nfall++;
                    if (hi_run != CLK_DIV) sclk_bad = 1'b1;
                end
            end

            if (!cs_prev && cs) begin
                k   = cs_falls - 1;
                chx = (k < NCH) ? k : NCH - 1;
                exp_cmd = 32'(chx) << 16;
                check("sclk_pulses", nrise, 32);
                check("sclk_high_width", 32'(sclk_bad), 0);
                check($sformatf("cmd_frame%0d", k), mosi_word, exp_cmd);
                cmd_hist.push_back(mosi_word[21:16]);
                gap_run = 0;
            end
            if (cs) gap_run++;

            cs_prev   = cs;
            sclk_prev = sclk;
        end
    end

    task automatic prep_sweep(input int mode);
        slave_mode  = mode;
        cs_falls    = 0;
        cmd_hist.delete();
        busy_cycles = 0;
        done_count  = 0;
        idle_bad    = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            exp_q.push_back({6'(c), (mode == 0) ? 16'hA002 + 16'(c) : 16'(c) + 16'd2});
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_sweep(input int mode, input bit extra_start);
        int n;
        prep_sweep(mode);
        pulse_start();
        check("busy_after_start", 32'(busy), 1);
        n = 0;
        while (busy && n < SWEEP_LEN + 1000) begin
            start = extra_start && (n == 300);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("sweep_timeout", 32'(busy), 0);
        @(negedge clk); #1;
        check("busy_cycles", busy_cycles, SWEEP_LEN);
        check("frame_done_count", done_count, 1);
        check("frames_per_sweep", cs_falls, NCH + 2);
        check("samples_left", exp_q.size(), 0);
        check("sclk_low_when_cs_high", 32'(idle_bad), 0);
        check("hold_channel", 32'(sample_channel), NCH - 1);
        check("hold_data", 32'(sample_data),
              (mode == 0) ? 32'(16'hA001 + 16'(NCH)) : 32'(NCH + 1));
        exp_q.delete();
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_CS", 32'(cs), 1);
        check("rst_SCLK", 32'(sclk), 0);
        check("rst_MOSI", 32'(mosi), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sample_valid", 32'(sample_valid), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_sample_data", 32'(sample_data), 0);
        check("rst_sample_channel", 32'(sample_channel), 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Basic sweep with the counting MISO model
        run_sweep(0, 1'b0);

        // start pulsed mid-sweep must be ignored
        run_sweep(0, 1'b1);

        // Reset in frame 5: frames 2..4 already produced channels 0..2
        prep_sweep(0);
        pulse_start();
        repeat (699) @(posedge clk);
        #1;
        check("pre_reset_samples_left", exp_q.size(), NCH - 3);
        rst = 1'b1;
        #1;
        check("abort_CS", 32'(cs), 1);
        check("abort_SCLK", 32'(sclk), 0);
        check("abort_busy", 32'(busy), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("abort_frame_done", done_count, 0);
        check("abort_idle_CS", 32'(cs), 1);
        run_sweep(0, 1'b0);

        // Pipelined slave: sample_data must be sample_channel + 2
        run_sweep(1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
